// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: two-road signal phase sequencer; define TLC_PED_EN to enable the pedestrian walk phase
module intersection_phase_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {NS_G = 3'd0, NS_Y = 3'd1, EW_G = 3'd2, EW_Y = 3'd3, ALLRED = 3'd4, WALK = 3'd5} state_t;
  localparam logic [8:0] GMIN = 9'(GREEN_MIN);
  localparam logic [8:0] GMAX = 9'(GREEN_MAX);
  localparam logic [8:0] YT   = 9'(YELLOW_T);
  localparam logic [8:0] AT   = 9'(ALLRED_T);
  localparam logic [8:0] WT   = 9'(WALK_T);
  state_t state, state_nx;
  logic next_dir, next_dir_nx;
  logic [7:0] elapsed;
  logic [8:0] n;
  logic ped_pending;
  // 9 bits so a saturated elapsed still yields n=256
  assign n = {1'b0, elapsed} + 9'd1;
  // next-state and next-direction decision, only on tick cycles
  always_comb begin
    state_nx = state;
    next_dir_nx = next_dir;
    if (tick)
      case (state)
        NS_G: if ((car_ew | ped_pending) && ((n >= GMIN && !car_ns) || n >= GMAX)) state_nx = NS_Y;
        NS_Y: if (n == YT) begin state_nx = ALLRED; next_dir_nx = 1'b1; end
        EW_G: if ((car_ns | ped_pending) && ((n >= GMIN && !car_ew) || n >= GMAX)) state_nx = EW_Y;
        EW_Y: if (n == YT) begin state_nx = ALLRED; next_dir_nx = 1'b0; end
        ALLRED: if (n == AT) state_nx = ped_pending ? WALK : (next_dir ? EW_G : NS_G);
        WALK: if (n == WT) state_nx = next_dir ? EW_G : NS_G;
        default: state_nx = ALLRED;
      endcase
  end
  // state, direction and saturating per-state tick counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ALLRED;
      next_dir <= 1'b0;
      elapsed <= 8'd0;
    end else begin
      state <= state_nx;
      next_dir <= next_dir_nx;
      elapsed <= (state_nx != state) ? 8'd0 : (tick && elapsed != 8'hff) ? elapsed + 8'd1 : elapsed;
    end
`ifdef TLC_PED_EN
  // latch button presses; walk entry consumes the request, including a press on that same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) ped_pending <= 1'b0;
    else if (state_nx == WALK && state != WALK) ped_pending <= 1'b0;
    else if (ped_req) ped_pending <= 1'b1;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ped_pending = 1'b0;
`endif
  // lamp and status decode, purely from registers
  always_comb begin
    light_ns = (state == NS_G) ? 3'b001 : (state == NS_Y) ? 3'b010 : 3'b100;
    light_ew = (state == EW_G) ? 3'b001 : (state == EW_Y) ? 3'b010 : 3'b100;
    walk = (state == WALK);
    ped_wait = ped_pending;
    phase = state;
  end
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: directed check of phase sequencing, timing, reset and tick gating
module tb_intersection_phase_scheduler;
  logic clk = 1'b0, rst, tick, car_ns, car_ew, ped_req;
  logic [2:0] light_ns, light_ew, phase;
  logic walk, ped_wait;
  int compared = 0, mismatched = 0;
`ifdef TLC_PED_EN
  localparam logic PED = 1'b1;
`else
  localparam logic PED = 1'b0;
`endif
  intersection_phase_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
    .light_ns(light_ns), .light_ew(light_ew), .walk(walk), .ped_wait(ped_wait), .phase(phase)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; tick = 1'b0; car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0;
    cyc(2);
    chk("rst_light_ns", light_ns, 3'b100);
    chk("rst_light_ew", light_ew, 3'b100);
    chk("rst_walk", walk, 0);
    chk("rst_ped_wait", ped_wait, 0);
    chk("rst_phase", phase, 4);
    rst = 1'b0; tick = 1'b1; car_ew = 1'b1;
    cyc(1);
    chk("first_tick_nsg", phase, 0);
    cyc(7);
    chk("gap_nsg_last", phase, 0);
    chk("gap_nsg_ns", light_ns, 3'b001);
    chk("gap_nsg_ew", light_ew, 3'b100);
    cyc(1);
    chk("gap_nsy", phase, 1);
    chk("gap_nsy_ns", light_ns, 3'b010);
    cyc(2);
    chk("gap_nsy_last", phase, 1);
    cyc(1);
    chk("gap_allred", phase, 4);
    cyc(1);
    chk("gap_ewg", phase, 2);
    chk("gap_ewg_ew", light_ew, 3'b001);
    chk("gap_ewg_ns", light_ns, 3'b100);
    cyc(3);
    chk("ewg_hold", phase, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_phase", phase, 4);
    chk("async_rst_ns", light_ns, 3'b100);
    chk("async_rst_ew", light_ew, 3'b100);
    @(negedge clk);
    chk("rst_held_phase", phase, 4);
    rst = 1'b0; car_ns = 1'b1; car_ew = 1'b1;
    cyc(1);
    chk("rel_nsg", phase, 0);
    cyc(31);
    chk("max_nsg_last", phase, 0);
    cyc(1);
    chk("max_nsy", phase, 1);
    cyc(1);
    tick = 1'b0;
    cyc(20);
    chk("gate_phase", phase, 1);
    chk("gate_elapsed", dut.elapsed, 1);
    tick = 1'b1;
    cyc(1);
    chk("gate_resume", phase, 1);
    chk("gate_resume_el", dut.elapsed, 2);
    cyc(1);
    chk("gate_allred", phase, 4);
    cyc(1);
    chk("gate_ewg", phase, 2);
    car_ew = 1'b0;
    cyc(7);
    chk("ew_gap_last", phase, 2);
    cyc(1);
    chk("ew_gap_ewy", phase, 3);
    chk("ew_gap_ewy_lamp", light_ew, 3'b010);
    cyc(3);
    chk("ew_allred", phase, 4);
    cyc(1);
    chk("back_nsg", phase, 0);
    car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b1;
    cyc(1);
    ped_req = 1'b0;
    chk("ped_wait_set", ped_wait, PED);
    cyc(6);
    chk("ped_nsg_last", phase, 0);
    cyc(1);
`ifdef TLC_PED_EN
    chk("ped_nsy", phase, 1);
    cyc(3);
    chk("ped_allred", phase, 4);
    chk("ped_wait_held", ped_wait, 1);
    cyc(1);
    chk("ped_walk", phase, 5);
    chk("ped_walk_lamp", walk, 1);
    chk("ped_wait_clr", ped_wait, 0);
    chk("ped_walk_ns", light_ns, 3'b100);
    chk("ped_walk_ew", light_ew, 3'b100);
    cyc(5);
    chk("ped_walk_last", walk, 1);
    cyc(1);
    chk("ped_ewg", phase, 2);
    chk("ped_walk_off", walk, 0);
    cyc(1000);
    chk("nodemand_phase", phase, 2);
    chk("nodemand_sat", dut.elapsed, 255);
`else
    chk("noped_hold", phase, 0);
    chk("noped_walk", walk, 0);
    cyc(1000);
    chk("nodemand_phase", phase, 0);
    chk("nodemand_sat", dut.elapsed, 255);
    chk("noped_wait", ped_wait, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Phase scheduler for a two-road (north-south / east-west) signalised intersection. It sequences green, yellow, all-red and an optional pedestrian walk phase from vehicle-sensor and push-button demand. Phase durations are measured in ticks of an external timebase enable. It drives the lamp outputs directly and sits between the sensor/button synchronisers and the lamp drivers.

## Interface
- GREEN_MIN, 8: minimum green duration, in ticks.
- GREEN_MAX, 32: maximum green duration when opposing demand is present, in ticks.
- YELLOW_T, 3: yellow duration, in ticks.
- ALLRED_T, 1: all-red clearance duration, in ticks.
- WALK_T, 6: pedestrian walk duration, in ticks.
- Legality: all parameters ≥1; GREEN_MIN ≤ GREEN_MAX ≤ 255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  timebase enable; timers advance only on cycles with tick=1.
- car_ns  in  1  level: NS vehicle waiting.
- car_ew  in  1  level: EW vehicle waiting.
- ped_req  in  1  pedestrian button; any 1-cycle pulse is latched.
- light_ns  out  3  {red,yellow,green}, one-hot.
- light_ew  out  3  {red,yellow,green}, one-hot.
- walk  out  1  pedestrian walk lamp.
- ped_wait  out  1  latched pedestrian request pending.
- phase  out  3  current state: 0 NS_G, 1 NS_Y, 2 EW_G, 3 EW_Y, 4 ALLRED, 5 WALK.

## Operation
- Registers:
  - state
  - next_dir (0=NS, 1=EW)
  - elapsed: 8-bit tick counter, saturating at 255
  - ped_pending
- All outputs are decoded from these registers; there are no combinational paths from inputs to outputs.
- Lamps per state:
  - NS_G: NS green, EW red.
  - NS_Y: NS yellow, EW red.
  - EW_G / EW_Y: mirrored.
  - ALLRED and WALK: both red.
- walk=1 only in WALK.
- elapsed clears to 0 on every state change. Otherwise it increments on tick cycles.
- On a tick cycle let n = elapsed+1 (the number of ticks completed in the state including the current one).
- Demand while in NS_G = car_ew | ped_pending. While in EW_G = car_ns | ped_pending.
- Transitions (evaluated only when tick=1):
  - NS_G→NS_Y when demand & ((n≥GREEN_MIN & !car_ns) | n≥GREEN_MAX). EW_G→EW_Y is the mirror, using car_ew.
  - With no demand, green holds indefinitely.
  - NS_Y→ALLRED at n==YELLOW_T; sets next_dir=EW. EW_Y→ALLRED likewise; sets next_dir=NS.
  - ALLRED at n==ALLRED_T: goes to WALK if ped_pending, else to the green of next_dir.
  - WALK at n==WALK_T: goes to the green of next_dir.
- ped_pending:
  - Set by ped_req in any cycle.
  - Cleared on the cycle the WALK state is entered.
  - A ped_req in that same entry cycle is absorbed and does not set it.
  - A ped_req during WALK re-latches it.
- Reset values:
  - state=ALLRED, next_dir=NS, elapsed=0, ped_pending=0.
  - Therefore light_ns=light_ew=3'b100, walk=0, ped_wait=0, phase=4.
- Reset mid-operation forces these values immediately, regardless of clk. No lamp state other than all-red is ever visible on reset.

## Timing
- State changes on the rising clk edge of the tick cycle that satisfies the condition. Outputs reflect the new state in that same cycle, after the edge.
- With tick held at 1, the state durations in cycles are: yellow = YELLOW_T, all-red = ALLRED_T, walk = WALK_T. Green lasts between GREEN_MIN and GREEN_MAX, or unbounded with no demand.
- tick=0 freezes elapsed and all transitions. ped_req is still latched while tick=0.
- Input changes take effect at the next qualifying tick edge. car_ns and car_ew are sampled only on tick cycles.
- ped_wait goes high the cycle after ped_req.

## Configuration
- TLC_PED_EN defined:
  - WALK state, ped_pending and ped_req are active as described above.
- TLC_PED_EN undefined:
  - ped_req is ignored; ped_pending is held at 0, so ped_wait=0 and walk=0.
  - WALK is unreachable.
  - Demand comes from vehicle sensors only.
  - ALLRED always goes to the green of next_dir.

## Test plan
- Reset mid-phase: rst pulse asserted during EW_G with tick=1 → both lights 3'b100 and phase=4 before the next edge. After release → NS_G on the 1st tick.
- Gap-out: defaults, car_ew=1, car_ns=0, tick=1 from NS_G entry → NS_G lasts 8 cycles, NS_Y 3 cycles, ALLRED 1 cycle, then EW_G.
- Max-out: car_ns=1, car_ew=1 → NS_G lasts 32 cycles, then NS_Y.
- No demand: cars 0, no ped_req, 1000 ticks in NS_G → state unchanged, elapsed pinned at 255.
- Pedestrian (TLC_PED_EN): 1-cycle ped_req in NS_G, cars 0:
  - ped_wait=1 on the next cycle.
  - NS_Y after 8 ticks, then ALLRED, then WALK for 6 cycles with walk=1.
  - ped_wait drops at WALK entry, then EW_G.
  - Without the macro: same stimulus → NS_G holds and walk stays 0.
- Tick gating: tick=0 for 20 cycles mid-yellow → phase and elapsed frozen. Yellow completes after the remaining ticks.
